watchdog_kick_mon: RTL and testbench
====================================

Name: watchdog_kick_mon

Overview:
Parametrised external-watchdog kick generator with multi-channel heartbeat supervision.
- Drives the WDI pin of the board watchdog IC with a square wave of programmable half-period.
- Toggling continues only while every enabled software/logic channel has pulsed its heartbeat within a timeout window.
- On a missed heartbeat, toggling freezes so the external watchdog resets the board. The failing channel is latched for diagnostics.

Parameters:
- CH_NUM, 4, number of supervised heartbeat channels (1..16)
- CNT_W, 25, prescaler counter width
- HALF_PERIOD, 24900, prescaler terminal count; WDI half-period = HALF_PERIOD+1 clk cycles
- TIMEOUT, 5, ticks without a heartbeat before a channel faults (2..255)
- TO_W, 8, width of the per-channel miss counter
- MIN_GAP, 1, minimum ticks between heartbeats (used only with WDOG_WINDOW_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_dog_en  in  1  1: supervision and kicking enabled; 0: disabled
- i_ch_en  in  CH_NUM  per-channel enable; a disabled channel never faults
- i_hb  in  CH_NUM  per-channel heartbeat, single-cycle pulse
- i_fault_clr  in  1  single-cycle pulse; clears latched faults
- o_wdi  out  1  kick output to the external watchdog IC
- o_fault  out  1  OR of o_fault_ch
- o_fault_ch  out  CH_NUM  latched per-channel fault flags
- o_state  out  2  FSM state: 0 IDLE, 1 RUN, 2 FAULT

Behaviour:
- Reset values: state IDLE, prescaler 0, o_wdi=1, o_fault_ch=0, o_fault=0, all miss counters 0. Every output is registered.
- Prescaler: runs only in RUN. Counts 0..HALF_PERIOD and wraps to 0. The wrap cycle generates an internal one-cycle tick. It is cleared to 0 on every entry to RUN.
- Miss counter (per channel):
  - Cleared by i_hb.
  - Otherwise incremented on tick, saturating at TIMEOUT.
  - If i_hb and tick occur in the same cycle, i_hb wins and the counter becomes 0.
  - Held at 0 while i_ch_en[n]=0 or the state is not RUN.
- Channel fault: o_fault_ch[n] is set on the edge where the counter transitions to TIMEOUT. It stays set until i_fault_clr.
- FSM:
  - IDLE: o_wdi forced 1. If i_dog_en=1, go to RUN when o_fault=0, else go to FAULT.
  - RUN: on entry o_wdi loads 0. o_wdi toggles on each tick, at the same edge the prescaler wraps. Any new channel fault moves to FAULT on the next edge; o_wdi is not toggled on the fault edge.
  - FAULT: o_wdi holds its last value and the prescaler stops. i_fault_clr clears all o_fault_ch and returns to RUN (re-entry rules apply).
  - From any state, i_dog_en=0 goes to IDLE on the next edge. Miss counters clear; o_fault_ch is retained.
- Simultaneous events:
  - i_fault_clr together with a new fault in RUN: the fault wins and stays set.
  - i_fault_clr together with i_dog_en=0: flags clear and the next state is IDLE.
- All-channels-disabled in RUN: kicks continuously.
- Mid-operation async reset: immediate return to reset values; o_wdi=1.

Optional Feature:
WDOG_WINDOW_EN
- Defined: window watchdog. A heartbeat arriving while the channel's miss counter is below MIN_GAP is an early-kick fault. It sets o_fault_ch[n] on the same edge, with the same FSM consequence as a timeout. The first heartbeat after entering RUN is exempt.
- Undefined: early heartbeats are accepted; MIN_GAP is ignored and no window logic is synthesised.

Decomposition:
- Package wdog_pkg: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_FAULT=2'd2) and the default TIMEOUT/HALF_PERIOD constants.
- Sub-module wdog_ch_mon, instantiated CH_NUM times by a generate loop. It holds one miss counter and the timeout/early-kick detect, and outputs a fault-set pulse.
- The top level holds the prescaler, FSM, o_wdi and the fault flag registers.

Test Plan (HALF_PERIOD=9, CH_NUM=2, TIMEOUT=3, MIN_GAP=1):
- Reset, then i_dog_en=1 with both channels enabled and heartbeats every 15 clk -> o_state=1; o_wdi 0/1 square wave, period 20 clk; o_fault stays 0 for 1000 clk.
- Ch1 heartbeats stop, ch0 continues -> o_fault_ch=2'b10 at the 3rd tick after the last ch1 heartbeat; o_state=2; o_wdi frozen; prescaler stops.
- In FAULT, pulse i_fault_clr with heartbeats restored -> flags 0, o_state=1, o_wdi=0 on entry and first toggle 10 clk later.
- i_hb[0] coincident with tick, repeated for 10 ticks -> miss counter reads 0 after each, no fault.
- i_dog_en dropped mid-RUN -> o_wdi=1 next edge, o_state=0; with a latched fault, re-enable goes straight to o_state=2.
- WDOG_WINDOW_EN defined: ch0 heartbeats 2 clk apart (both before any tick) -> o_fault_ch[0] set on the 2nd heartbeat edge. With the macro undefined -> no fault.

Source files
------------

// File: rtl/wdog_pkg.sv
// wdog_pkg: shared state encoding and default timing constants for watchdog_kick_mon
//   state_t         : FSM state encoding driven onto o_state (IDLE/RUN/FAULT)
//   DEF_TIMEOUT     : default number of missed ticks before a channel faults
//   DEF_HALF_PERIOD : default prescaler terminal count (WDI half-period minus one)
package wdog_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
    localparam int unsigned DEF_TIMEOUT     = 5;
    localparam int unsigned DEF_HALF_PERIOD = 24900;
endpackage

// File: rtl/watchdog_kick_mon_if.sv
// watchdog_kick_mon_if: control/status bundle between the watchdog kick monitor and its host
//   i_dog_en    : global enable for supervision and kicking
//   i_ch_en     : per-channel supervision enable
//   i_hb        : per-channel single-cycle heartbeat pulses
//   i_fault_clr : single-cycle pulse clearing latched faults
//   o_wdi       : kick output to the external watchdog IC
//   o_fault     : OR of all latched channel faults
//   o_fault_ch  : latched per-channel fault flags
//   o_state     : FSM state (IDLE/RUN/FAULT)
// master drives the inputs (host/testbench), slave is the monitor itself.
interface watchdog_kick_mon_if
    import wdog_pkg::*;
#(
    parameter int unsigned CH_NUM = 4
);
    logic              i_dog_en;
    logic [CH_NUM-1:0] i_ch_en;
    logic [CH_NUM-1:0] i_hb;
    logic              i_fault_clr;
    logic              o_wdi;
    logic              o_fault;
    logic [CH_NUM-1:0] o_fault_ch;
    state_t            o_state;

    modport master (
        output i_dog_en, i_ch_en, i_hb, i_fault_clr,
        input  o_wdi, o_fault, o_fault_ch, o_state
    );

    modport slave (
        input  i_dog_en, i_ch_en, i_hb, i_fault_clr,
        output o_wdi, o_fault, o_fault_ch, o_state
    );
endinterface

// File: rtl/wdog_ch_mon.sv
// wdog_ch_mon: one heartbeat channel; miss counter plus timeout (and optional early-kick) detect
//   clk, rst_n : clock, asynchronous active-low reset
//   i_run      : monitor is in RUN
//   i_en       : this channel is enabled
//   i_hb       : heartbeat pulse
//   i_tick     : prescaler wrap tick
//   o_set      : combinational fault-set pulse, registered by the top
// Optional build macro WDOG_WINDOW_EN adds the early-heartbeat (window) check.
module wdog_ch_mon #(
    parameter int unsigned TIMEOUT = 5,
    parameter int unsigned TO_W    = 8
`ifdef WDOG_WINDOW_EN
    ,
    parameter int unsigned MIN_GAP = 1
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_en,
    input  logic i_hb,
    input  logic i_tick,
    output logic o_set
);
    logic [TO_W-1:0] r_cnt;
    logic            w_act;
    logic            w_to;

    assign w_act = i_run && i_en;
    // Timeout fires on the edge where the counter would step onto TIMEOUT; a heartbeat in the same cycle wins.
    assign w_to  = w_act && !i_hb && i_tick && (r_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (!w_act || i_hb) ? '0 :
                     (i_tick && r_cnt != TO_W'(TIMEOUT)) ? r_cnt + 1'b1 : r_cnt;
    end

`ifdef WDOG_WINDOW_EN
    logic r_seen;
    logic w_early;

    // r_seen marks that a heartbeat has arrived since the channel became active, so the first one is exempt.
    assign w_early = w_act && i_hb && r_seen && (r_cnt < TO_W'(MIN_GAP));
    assign o_set   = w_to || w_early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_seen <= 1'b0;
        else
            r_seen <= w_act && (r_seen || i_hb);
    end
`else
    assign o_set = w_to;
`endif
endmodule

// File: rtl/watchdog_kick_mon.sv
// watchdog_kick_mon: external-watchdog WDI kick generator gated by multi-channel heartbeat supervision
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : watchdog_kick_mon_if.slave (i_dog_en, i_ch_en, i_hb, i_fault_clr,
//                o_wdi, o_fault, o_fault_ch, o_state)
// Holds the prescaler, the IDLE/RUN/FAULT FSM, o_wdi and the latched fault flags;
// one wdog_ch_mon per channel does the miss counting.
// Optional build macro WDOG_WINDOW_EN enables early-heartbeat (window) faults using MIN_GAP.
module watchdog_kick_mon
    import wdog_pkg::*;
#(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned MIN_GAP     = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    watchdog_kick_mon_if.slave  bus
);
    if (CH_NUM < 1 || CH_NUM > 16 || TIMEOUT < 2 || TIMEOUT > 255 || MIN_GAP >= TIMEOUT) begin : g_bad_cfg
        $error("watchdog_kick_mon: parameter out of range");
    end

    state_t            r_state;
    logic [CNT_W-1:0]  r_presc;
    logic              r_wdi;
    logic [CH_NUM-1:0] r_fault_ch;
    logic              r_fault;
    logic              w_run;
    logic              w_tick;
    logic [CH_NUM-1:0] w_set;
    logic [CH_NUM-1:0] w_flags_nxt;

    assign w_run  = (r_state == ST_RUN);
    assign w_tick = w_run && (r_presc == CNT_W'(HALF_PERIOD));

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        wdog_ch_mon #(
            .TIMEOUT (TIMEOUT),
            .TO_W    (TO_W)
`ifdef WDOG_WINDOW_EN
            ,
            .MIN_GAP (MIN_GAP)
`endif
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_run  (w_run),
            .i_en   (bus.i_ch_en[g]),
            .i_hb   (bus.i_hb[g]),
            .i_tick (w_tick),
            .o_set  (w_set[g])
        );
    end

    // A fault raised in the same cycle as a clear survives the clear.
    assign w_flags_nxt = bus.i_fault_clr ? w_set : (r_fault_ch | w_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_wdi      <= 1'b1;
            r_fault_ch <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_fault_ch <= w_flags_nxt;
            r_fault    <= |w_flags_nxt;
            if (!bus.i_dog_en) begin
                r_state <= ST_IDLE;
                r_presc <= '0;
                r_wdi   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_fault) begin
                            r_state <= ST_FAULT;
                        end else begin
                            r_state <= ST_RUN;
                            r_presc <= '0;
                            r_wdi   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // On the fault edge WDI is frozen, even if a tick coincides.
                        if (|w_set) begin
                            r_state <= ST_FAULT;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            r_wdi   <= ~r_wdi;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (bus.i_fault_clr) begin
                            r_state <= ST_RUN;
                            r_presc <= '0;
                            r_wdi   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_presc <= '0;
                        r_wdi   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.o_wdi      = r_wdi;
    assign bus.o_fault    = r_fault;
    assign bus.o_fault_ch = r_fault_ch;
    assign bus.o_state    = r_state;
endmodule

// File: tb/tb_watchdog_kick_mon.sv
// tb_watchdog_kick_mon: vector table, corner sequences and randomized run against a time-based model
module tb_watchdog_kick_mon;
    localparam int HP      = 9;
    localparam int TO      = 3;
    localparam int MIN_GAP = 1;
`ifdef WDOG_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    watchdog_kick_mon_if #(.CH_NUM(2)) bus ();

    watchdog_kick_mon #(
        .CH_NUM      (2),
        .CNT_W       (25),
        .HALF_PERIOD (HP),
        .TIMEOUT     (TO),
        .TO_W        (8),
        .MIN_GAP     (MIN_GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit       en;
        bit [1:0] ce;
        bit [1:0] hb;
        bit       clr;
        int       wt;
        bit [1:0] st;
        bit [1:0] fl;
        bit       wdi;
    } vec_t;

    vec_t tbl [19];

    // Model: RUN time is measured as cycles since RUN entry; a tick is every (HP+1)-th such cycle.
    // Each channel counts whole ticks since its last heartbeat; it faults when that count reaches TO.
    bit [1:0] m_state;
    bit       m_wdi;
    bit [1:0] m_flags;
    bit       m_fault;
    int       m_age;
    int       m_miss [2];
    bit       m_seen [2];

    task automatic model_reset();
        m_state = 2'd0;
        m_wdi   = 1'b1;
        m_flags = 2'b00;
        m_fault = 1'b0;
        m_age   = 0;
        for (int c = 0; c < 2; c++) begin
            m_miss[c] = 0;
            m_seen[c] = 1'b0;
        end
    endtask

    task automatic model_step(input bit en, input bit [1:0] ce, input bit [1:0] hb, input bit clr);
        bit       tick;
        bit [1:0] set;
        bit       old_fault;
        tick = (m_state == 2'd1) && ((m_age % (HP + 1)) == HP);
        set  = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (m_state != 2'd1 || !ce[c]) begin
                m_miss[c] = 0;
                m_seen[c] = 1'b0;
            end else if (hb[c]) begin
                if (WIN && m_seen[c] && m_miss[c] < MIN_GAP) set[c] = 1'b1;
                m_miss[c] = 0;
                m_seen[c] = 1'b1;
            end else if (tick) begin
                m_miss[c]++;
                if (m_miss[c] == TO) set[c] = 1'b1;
            end
        end
        old_fault = m_fault;
        m_flags   = clr ? set : (m_flags | set);
        m_fault   = |m_flags;
        if (!en) begin
            m_state = 2'd0;
            m_wdi   = 1'b1;
        end else if (m_state == 2'd0) begin
            if (old_fault) m_state = 2'd2;
            else begin
                m_state = 2'd1;
                m_age   = 0;
                m_wdi   = 1'b0;
            end
        end else if (m_state == 2'd1) begin
            if (set != 2'b00) m_state = 2'd2;
            else begin
                if (tick) m_wdi = !m_wdi;
                m_age++;
            end
        end else if (clr) begin
            m_state = 2'd1;
            m_age   = 0;
            m_wdi   = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] obs();
        return {bus.o_state, bus.o_fault_ch, bus.o_wdi, bus.o_fault};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bus.i_dog_en    = v.en;
        bus.i_ch_en     = v.ce;
        bus.i_hb        = v.hb;
        bus.i_fault_clr = v.clr;
        step();
        bus.i_hb        = 2'b00;
        bus.i_fault_clr = 1'b0;
        repeat (v.wt) step();
        chk($sformatf("vec%0d", idx), 32'(obs()), 32'({v.st, v.fl, v.wdi, |v.fl}));
    endtask

    initial begin
        bit       r_en;
        bit [1:0] r_ce;
        bit [1:0] r_hb;
        bit       r_clr;

        tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 0,  2'd1, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 2'b00, 1'b0, 8,  2'd1, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 2'b00, 1'b0, 0,  2'd1, 2'b00, 1'b1};
        tbl[3]  = '{1'b1, 2'b11, 2'b00, 1'b0, 0,  2'd1, 2'b00, 1'b1};
        tbl[4]  = '{1'b1, 2'b11, 2'b00, 1'b0, 27, 2'd1, 2'b00, 1'b1};
        tbl[5]  = '{1'b1, 2'b11, 2'b01, 1'b0, 0,  2'd2, 2'b10, 1'b1};
        tbl[6]  = '{1'b1, 2'b11, 2'b00, 1'b0, 4,  2'd2, 2'b10, 1'b1};
        tbl[7]  = '{1'b1, 2'b11, 2'b00, 1'b1, 0,  2'd1, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 2'b00, 1'b0, 7,  2'd1, 2'b00, 1'b0};
        tbl[9]  = '{1'b1, 2'b11, 2'b11, 1'b0, 0,  2'd1, 2'b00, 1'b0};
        tbl[10] = '{1'b1, 2'b11, 2'b00, 1'b0, 0,  2'd1, 2'b00, 1'b1};
        tbl[11] = '{1'b0, 2'b11, 2'b00, 1'b0, 0,  2'd0, 2'b00, 1'b1};
        tbl[12] = '{1'b1, 2'b11, 2'b00, 1'b0, 0,  2'd1, 2'b00, 1'b0};
        tbl[13] = '{1'b1, 2'b11, 2'b00, 1'b0, 28, 2'd1, 2'b00, 1'b0};
        tbl[14] = '{1'b1, 2'b11, 2'b00, 1'b0, 0,  2'd2, 2'b11, 1'b0};
        tbl[15] = '{1'b0, 2'b11, 2'b00, 1'b0, 0,  2'd0, 2'b11, 1'b1};
        tbl[16] = '{1'b1, 2'b11, 2'b00, 1'b0, 0,  2'd2, 2'b11, 1'b1};
        tbl[17] = '{1'b1, 2'b11, 2'b00, 1'b1, 0,  2'd1, 2'b00, 1'b0};
        tbl[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 0,  2'd0, 2'b00, 1'b1};

        bus.i_dog_en    = 1'b0;
        bus.i_ch_en     = 2'b00;
        bus.i_hb        = 2'b00;
        bus.i_fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs()), 32'({2'd0, 2'b00, 1'b1, 1'b0}));
        chk("reset_cnt0", 32'(dut.g_ch[0].u_ch.r_cnt), 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(tbl[i], i);

        // Heartbeat landing on the tick edge clears the counter instead of advancing it.
        bus.i_dog_en = 1'b1;
        bus.i_ch_en  = 2'b01;
        step();
        for (int k = 0; k < 10; k++) begin
            repeat (9) step();
            bus.i_hb = 2'b01;
            step();
            bus.i_hb = 2'b00;
            chk($sformatf("hb_on_tick_cnt%0d", k), 32'(dut.g_ch[0].u_ch.r_cnt), 32'd0);
            chk($sformatf("hb_on_tick_fault%0d", k), 32'(bus.o_fault), 32'(WIN && k > 0));
        end
        bus.i_dog_en    = 1'b0;
        bus.i_fault_clr = 1'b1;
        step();
        bus.i_fault_clr = 1'b0;
        chk("drop_with_clr", 32'(obs()), 32'({2'd0, 2'b00, 1'b1, 1'b0}));

        // Clear pulse coinciding with a fresh timeout: the fault stays latched.
        bus.i_dog_en = 1'b1;
        step();
        repeat (29) step();
        bus.i_fault_clr = 1'b1;
        step();
        bus.i_fault_clr = 1'b0;
        chk("clr_vs_new_fault", 32'(obs()), 32'({2'd2, 2'b01, 1'b0, 1'b1}));

        // Two heartbeats two cycles apart right after RUN entry.
        bus.i_fault_clr = 1'b1;
        step();
        bus.i_fault_clr = 1'b0;
        chk("reenter_run", 32'(obs()), 32'({2'd1, 2'b00, 1'b0, 1'b0}));
        bus.i_hb = 2'b01;
        step();
        bus.i_hb = 2'b00;
        step();
        bus.i_hb = 2'b01;
        step();
        bus.i_hb = 2'b00;
        chk("early_hb", 32'(obs()), WIN ? 32'({2'd2, 2'b01, 1'b0, 1'b1}) : 32'({2'd1, 2'b00, 1'b0, 1'b0}));

        // Asynchronous reset in the middle of a cycle.
        bus.i_fault_clr = 1'b1;
        step();
        bus.i_fault_clr = 1'b0;
        repeat (15) step();
        chk("pre_async_wdi", 32'(bus.o_wdi), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(obs()), 32'({2'd0, 2'b00, 1'b1, 1'b0}));
        bus.i_dog_en = 1'b0;
        bus.i_ch_en  = 2'b11;
        step();
        #2 rst_n = 1'b1;
        model_reset();
        r_ce = 2'b11;

        for (int n = 0; n < 4000; n++) begin
            r_en  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) == 0) r_ce = 2'($urandom_range(0, 3));
            r_hb  = {($urandom_range(0, 13) == 0), ($urandom_range(0, 13) == 0)};
            r_clr = ($urandom_range(0, 29) == 0);
            bus.i_dog_en    = r_en;
            bus.i_ch_en     = r_ce;
            bus.i_hb        = r_hb;
            bus.i_fault_clr = r_clr;
            model_step(r_en, r_ce, r_hb, r_clr);
            step();
            chk($sformatf("rand%0d", n), 32'(obs()), 32'({m_state, m_flags, m_wdi, m_fault}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
